cpu_seq_ctrl: RTL and testbench
===============================

CPU_SEQ_CTRL -- requirements
Module: cpu_seq_ctrl

Interface
REQ-001 SHALL take parameter TIMEOUT_CYC, default 255: bus watchdog limit in cycles (used only under CPU_SEQ_TIMEOUT_EN).
REQ-002 SHALL take parameter RESET_PC, default 32'h0000_0000: informational restart address driven on rst_pc.
REQ-003 SHALL have ports, in this order:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- RUN  in  1  level enable; 0 = stop at the next instruction boundary
- start_transaction  out  1  one-cycle bus request pulse
- mode  out  1  bus direction: 0 = read, 1 = write
- rdata_valid  in  1  read data valid
- write_done  in  1  write complete
- rdata  in  32  bus read data
- addr_CS  out  2  bus address select: 0 = PC, 1 = ALU
- data_CS  out  3  bus write-data select: 2 = reg_rdata2
- PC_CS  out  2  PC source: 0 = +4, 1 = ALU
- PC_mode  out  1  1 = branch-taken path
- PC_EN  out  1  PC update strobe
- reg_CS  out  3  regfile write mux: 0 = ALU, 3 = PC, 5 = load data
- reg_wen  out  1  regfile write strobe
- ALU_mode  out  1  0 = add, 1 = subtract/compare
- ALU_CS  out  2  ALU operand-1 select: 0 = reg, 1 = PC
- IR  out  32  latched instruction
- rs1, rs2, rd  out  5 each  IR[19:15], IR[24:20], IR[11:7]
- rst_pc  out  32  constant RESET_PC
- halted  out  1  sticky illegal-instruction / timeout flag

Function
REQ-004 SHALL implement the states IDLE, F_REQ, F_WAIT, DECODE, EXEC, M_REQ, M_WAIT, TRAP.
REQ-005 IDLE SHALL move to F_REQ when RUN=1 and halted=0; otherwise it stays in IDLE.
REQ-006 F_REQ SHALL pulse start_transaction for exactly one cycle with mode=0 and addr_CS=0, then move to F_WAIT.
REQ-007 F_WAIT SHALL latch rdata into IR on the cycle rdata_valid=1, then move to DECODE; write_done is ignored in F_WAIT.
REQ-008 DECODE SHALL classify IR[6:0] and move to EXEC for 0110011, 0010011, 0000011, 0100011, 1100011 and 1101111; every other value goes to TRAP.
REQ-009 EXEC behaviour by instruction class:
- ALU (OP/OP-IMM): reg_wen=1, reg_CS=0, PC_EN=1, PC_CS=0, then go to IDLE.
- BRANCH: ALU_mode=1; PC_EN=1, with PC_mode=1 and PC_CS=1 when the branch is taken, else PC_CS=0; then go to IDLE.
- JAL: reg_wen=1, reg_CS=3, ALU_CS=1, PC_CS=1, PC_EN=1; then go to IDLE.
- LOAD/STORE: go to M_REQ.
REQ-010 M_REQ SHALL pulse start_transaction with addr_CS=1; mode=1 and data_CS=2 for STORE, mode=0 for LOAD.
REQ-011 M_WAIT SHALL complete on rdata_valid (LOAD) or write_done (STORE).
- On completion: PC_EN=1 with PC_CS=0; LOAD also sets reg_wen=1, reg_CS=5.
- Then go to IDLE.
REQ-012 Fetch+ALU instruction SHALL take 4+W cycles, where W is the number of F_WAIT cycles before rdata_valid.
REQ-013 A branch is taken when the zero flag (derived from rdata==0 compare input) is set; this flag SHALL be sampled in EXEC.
REQ-014 RUN falling mid-instruction SHALL NOT abort the instruction; RUN is checked only in IDLE.
REQ-015 reg_wen, PC_EN and start_transaction SHALL each be high for at most one cycle per instruction.
REQ-016 rd=0 SHALL suppress reg_wen.
REQ-017 TRAP SHALL set halted=1 and hold until reset; all strobes are 0 in TRAP.
REQ-018 rdata_valid and write_done arriving outside F_WAIT/M_WAIT SHALL be ignored.

Reset
REQ-019 With rst_n=0 at a clock edge:
- state=IDLE, IR=0, halted=0.
- All strobes and selects are 0.
- Watchdog counter is 0.
REQ-020 Reset mid-transaction SHALL abandon the bus access; no pulse is issued on the reset cycle.

Configuration
REQ-021 With CPU_SEQ_TIMEOUT_EN defined:
- An 8-bit+ counter counts cycles spent in F_WAIT or M_WAIT.
- Reaching TIMEOUT_CYC moves the FSM to TRAP with halted=1.
REQ-022 Without CPU_SEQ_TIMEOUT_EN: no counter exists, and the wait states wait indefinitely.

Structure
REQ-023 Package cpu_seq_pkg SHALL hold:
- the state enum;
- the opcode constants;
- the addr_CS, data_CS, reg_CS, PC_CS and ALU_CS encodings.
REQ-024 One sub-module, cpu_seq_decode, SHALL map IR to the class and legality signals (combinational).

Verification
REQ-025 ADD fetch, rdata_valid after 2 wait cycles -> reg_wen and PC_EN pulse together exactly 6 cycles after the first IDLE exit.
REQ-026 LOAD 0x0000A083 -> second start_transaction with addr_CS=1, mode=0; on rdata_valid: reg_CS=5, reg_wen=1, rd=1.
REQ-027 STORE 0x0020A023 -> mode=1, data_CS=2; write_done -> PC_EN=1, reg_wen stays 0.
REQ-028 IR=0xFFFFFFFF -> TRAP, halted=1; RUN toggling produces no further start_transaction until rst_n=0.
REQ-029 RUN dropped during F_WAIT -> the instruction completes, then the FSM stays in IDLE.
REQ-030 Under CPU_SEQ_TIMEOUT_EN with TIMEOUT_CYC=8 and no rdata_valid -> halted=1 after 8 F_WAIT cycles.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared types and encodings for the CPU sequencer.
// Holds the FSM state enum, the RV32 major-opcode constants, the
// instruction-class enum produced by the decoder, and the mux-select
// encodings driven onto the datapath.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    F_REQ,
    F_WAIT,
    DECODE,
    EXEC,
    M_REQ,
    M_WAIT,
    TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_ILLEGAL
  } ins_class_t;

  // Major opcodes (IR[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Bus address select
  localparam logic [1:0] ADDR_PC   = 2'd0;
  localparam logic [1:0] ADDR_ALU  = 2'd1;
  // Bus write-data select
  localparam logic [2:0] DATA_NONE = 3'd0;
  localparam logic [2:0] DATA_RS2  = 3'd2;
  // Register-file write mux
  localparam logic [2:0] REG_ALU   = 3'd0;
  localparam logic [2:0] REG_PC    = 3'd3;
  localparam logic [2:0] REG_LOAD  = 3'd5;
  // PC source
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_ALU    = 2'd1;
  // ALU operand-1 select
  localparam logic [1:0] ALU1_REG  = 2'd0;
  localparam logic [1:0] ALU1_PC   = 2'd1;

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// cpu_seq_ctrl_if: link between the sequencer FSM (master) and the
// instruction decoder (slave). The master presents the latched opcode,
// the slave returns the instruction class and its legality.
interface cpu_seq_ctrl_if;
  import cpu_seq_pkg::*;

  logic [6:0] opcode;
  ins_class_t cls;
  logic       legal;

  modport master (output opcode, input cls, input legal);
  modport slave  (input opcode, output cls, output legal);
endinterface

// File: rtl/cpu_seq_decode.sv
// cpu_seq_decode: purely combinational classification of the latched
// opcode into an instruction class plus a legality flag.
module cpu_seq_decode
  import cpu_seq_pkg::*;
(
  cpu_seq_ctrl_if.slave dec
);

  // Opcode -> class; anything unrecognised is illegal
  always_comb begin
    dec.cls   = CLS_ILLEGAL;
    dec.legal = 1'b0;
    case (dec.opcode)
      OPC_OP, OPC_OP_IMM: begin dec.cls = CLS_ALU;    dec.legal = 1'b1; end
      OPC_LOAD:           begin dec.cls = CLS_LOAD;   dec.legal = 1'b1; end
      OPC_STORE:          begin dec.cls = CLS_STORE;  dec.legal = 1'b1; end
      OPC_BRANCH:         begin dec.cls = CLS_BRANCH; dec.legal = 1'b1; end
      OPC_JAL:            begin dec.cls = CLS_JAL;    dec.legal = 1'b1; end
      default:            ;
    endcase
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle instruction sequencer (fetch, decode,
// execute, optional memory access). Optional bus watchdog enabled by
// defining CPU_SEQ_TIMEOUT_EN; without it the wait states wait forever.
module cpu_seq_ctrl
  import cpu_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RUN,
  output logic        start_transaction,
  output logic        mode,
  input  logic        rdata_valid,
  input  logic        write_done,
  input  logic [31:0] rdata,
  output logic [1:0]  addr_CS,
  output logic [2:0]  data_CS,
  output logic [1:0]  PC_CS,
  output logic        PC_mode,
  output logic        PC_EN,
  output logic [2:0]  reg_CS,
  output logic        reg_wen,
  output logic        ALU_mode,
  output logic [1:0]  ALU_CS,
  output logic [31:0] IR,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] rst_pc,
  output logic        halted
);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_ir;
  logic        r_halted;
  logic        w_rd_nz;
  logic        w_zero;
  logic        w_is_store;
  logic        w_wd_expired;

  cpu_seq_ctrl_if u_dec_if ();
  assign u_dec_if.opcode = r_ir[6:0];

  cpu_seq_decode u_decode (
    .dec (u_dec_if.slave)
  );

  assign w_rd_nz    = |r_ir[11:7];
  assign w_zero     = (rdata == 32'd0);
  assign w_is_store = (u_dec_if.cls == CLS_STORE);

`ifdef CPU_SEQ_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [WD_W-1:0] r_wd_cnt;
  logic            w_in_wait;

  assign w_in_wait    = (r_state == F_WAIT) || (r_state == M_WAIT);
  // Fires on the last permitted wait cycle so TRAP follows exactly TIMEOUT_CYC waits
  assign w_wd_expired = w_in_wait && (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  // Count consecutive wait-state cycles; every exit from a wait passes a non-wait state
  always_ff @(posedge clk) begin
    if (!rst_n)         r_wd_cnt <= '0;
    else if (w_in_wait) r_wd_cnt <= r_wd_cnt + 1'b1;
    else                r_wd_cnt <= '0;
  end
`else
  assign w_wd_expired = 1'b0;
`endif

  // State, instruction and sticky halt registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ir     <= 32'd0;
      r_halted <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == F_WAIT && rdata_valid) r_ir <= rdata;
      if (w_state_next == TRAP)             r_halted <= 1'b1;
    end
  end

  // Next state and strobes; everything is forced low while reset is asserted
  always_comb begin
    w_state_next      = r_state;
    start_transaction = 1'b0;
    mode              = 1'b0;
    addr_CS           = ADDR_PC;
    data_CS           = DATA_NONE;
    PC_CS             = PC_PLUS4;
    PC_mode           = 1'b0;
    PC_EN             = 1'b0;
    reg_CS            = REG_ALU;
    reg_wen           = 1'b0;
    ALU_mode          = 1'b0;
    ALU_CS            = ALU1_REG;
    if (rst_n) begin
      case (r_state)
        IDLE: if (RUN && !r_halted) w_state_next = F_REQ;
        F_REQ: begin
          start_transaction = 1'b1;
          w_state_next      = F_WAIT;
        end
        F_WAIT: begin
          if (rdata_valid)       w_state_next = DECODE;
          else if (w_wd_expired) w_state_next = TRAP;
        end
        DECODE: w_state_next = u_dec_if.legal ? EXEC : TRAP;
        EXEC: begin
          w_state_next = IDLE;
          case (u_dec_if.cls)
            CLS_ALU: begin
              reg_wen = w_rd_nz;
              PC_EN   = 1'b1;
            end
            CLS_BRANCH: begin
              ALU_mode = 1'b1;
              PC_EN    = 1'b1;
              if (w_zero) begin
                PC_mode = 1'b1;
                PC_CS   = PC_ALU;
              end
            end
            CLS_JAL: begin
              reg_wen = w_rd_nz;
              reg_CS  = REG_PC;
              ALU_CS  = ALU1_PC;
              PC_CS   = PC_ALU;
              PC_EN   = 1'b1;
            end
            CLS_LOAD, CLS_STORE: w_state_next = M_REQ;
            default:             w_state_next = TRAP;
          endcase
        end
        M_REQ, M_WAIT: begin
          // Address/direction/data selects stay valid for the whole access
          addr_CS = ADDR_ALU;
          if (w_is_store) begin
            mode    = 1'b1;
            data_CS = DATA_RS2;
          end
          if (r_state == M_REQ) begin
            start_transaction = 1'b1;
            w_state_next      = M_WAIT;
          end else if (w_is_store ? write_done : rdata_valid) begin
            PC_EN        = 1'b1;
            w_state_next = IDLE;
            if (!w_is_store) begin
              reg_wen = w_rd_nz;
              reg_CS  = REG_LOAD;
            end
          end else if (w_wd_expired) begin
            w_state_next = TRAP;
          end
        end
        TRAP:    w_state_next = TRAP;
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign IR     = r_ir;
  assign rs1    = r_ir[19:15];
  assign rs2    = r_ir[24:20];
  assign rd     = r_ir[11:7];
  assign rst_pc = RESET_PC;
  assign halted = r_halted;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: directed, table-driven bench for cpu_seq_ctrl.
// Each table entry fetches one instruction and checks the execute and
// memory-phase outputs; reset, trap and watchdog cases are hand-written.
module tb_cpu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RUN;
  logic        start_transaction;
  logic        mode;
  logic        rdata_valid;
  logic        write_done;
  logic [31:0] rdata;
  logic [1:0]  addr_CS;
  logic [2:0]  data_CS;
  logic [1:0]  PC_CS;
  logic        PC_mode;
  logic        PC_EN;
  logic [2:0]  reg_CS;
  logic        reg_wen;
  logic        ALU_mode;
  logic [1:0]  ALU_CS;
  logic [31:0] IR;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rst_pc;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;
  int n_start, n_wen, n_pcen;
  int cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  cpu_seq_ctrl #(.TIMEOUT_CYC(8), .RESET_PC(32'h0000_1000)) dut (
    .clk (clk), .rst_n (rst_n), .RUN (RUN),
    .start_transaction (start_transaction), .mode (mode),
    .rdata_valid (rdata_valid), .write_done (write_done), .rdata (rdata),
    .addr_CS (addr_CS), .data_CS (data_CS), .PC_CS (PC_CS), .PC_mode (PC_mode),
    .PC_EN (PC_EN), .reg_CS (reg_CS), .reg_wen (reg_wen), .ALU_mode (ALU_mode),
    .ALU_CS (ALU_CS), .IR (IR), .rs1 (rs1), .rs2 (rs2), .rd (rd),
    .rst_pc (rst_pc), .halted (halted)
  );

  // Output bundle: {start,mode,addr_CS,data_CS,PC_CS,PC_mode,PC_EN,reg_CS,reg_wen,ALU_mode,ALU_CS,halted}
  function automatic logic [18:0] mk(input logic st, input logic md, input logic [1:0] ad,
                                     input logic [2:0] dc, input logic [1:0] pcs, input logic pm,
                                     input logic pe, input logic [2:0] rc, input logic we,
                                     input logic am, input logic [1:0] ac, input logic h);
    return {st, md, ad, dc, pcs, pm, pe, rc, we, am, ac, h};
  endfunction

  function automatic logic [18:0] outs();
    return {start_transaction, mode, addr_CS, data_CS, PC_CS, PC_mode, PC_EN,
            reg_CS, reg_wen, ALU_mode, ALU_CS, halted};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Settle, then tally strobes seen in this cycle
  task automatic samp();
    #1;
    if (start_transaction === 1'b1) n_start++;
    if (reg_wen === 1'b1)           n_wen++;
    if (PC_EN === 1'b1)             n_pcen++;
  endtask

  // kind: 0 = no memory phase, 1 = load, 2 = store, 3 = illegal (trap)
  typedef struct {
    logic [31:0] instr;
    int          wait_cyc;
    logic [31:0] cmp_rdata;
    logic [14:0] exp_regs;   // {rs1, rs2, rd}
    logic [18:0] exp_exec;
    int          kind;
    logic [18:0] exp_mreq;
    logic [18:0] exp_done;
    int          exp_wen;
  } vec_t;

  vec_t vecs [11];

  initial begin
    // ADD x1,x2,x3 with two empty fetch-wait cycles
    vecs[0]  = '{32'h003100B3, 2, 32'h7, {5'd2, 5'd3, 5'd1},
                 mk(0,0,0,0, 0,0,1, 0,1, 0,0, 0), 0, '0, '0, 1};
    // ADDI x0 (nop): rd=0 suppresses the write
    vecs[1]  = '{32'h00000013, 0, 32'h0, {5'd0, 5'd0, 5'd0},
                 mk(0,0,0,0, 0,0,1, 0,0, 0,0, 0), 0, '0, '0, 0};
    // ADDI x5,x0,1
    vecs[2]  = '{32'h00100293, 1, 32'h0, {5'd0, 5'd1, 5'd5},
                 mk(0,0,0,0, 0,0,1, 0,1, 0,0, 0), 0, '0, '0, 1};
    // BEQ, compare result zero -> taken
    vecs[3]  = '{32'h00000063, 0, 32'h0, {5'd0, 5'd0, 5'd0},
                 mk(0,0,0,0, 1,1,1, 0,0, 1,0, 0), 0, '0, '0, 0};
    // BEQ, compare result nonzero -> not taken
    vecs[4]  = '{32'h00000063, 1, 32'h5, {5'd0, 5'd0, 5'd0},
                 mk(0,0,0,0, 0,0,1, 0,0, 1,0, 0), 0, '0, '0, 0};
    // JAL x1
    vecs[5]  = '{32'h008000EF, 0, 32'h0, {5'd0, 5'd8, 5'd1},
                 mk(0,0,0,0, 1,0,1, 3,1, 0,1, 0), 0, '0, '0, 1};
    // JAL x0: jump without link write
    vecs[6]  = '{32'h0000006F, 0, 32'h0, {5'd0, 5'd0, 5'd0},
                 mk(0,0,0,0, 1,0,1, 3,0, 0,1, 0), 0, '0, '0, 0};
    // LW x1,0(x1)
    vecs[7]  = '{32'h0000A083, 1, 32'h0, {5'd1, 5'd0, 5'd1},
                 mk(0,0,0,0, 0,0,0, 0,0, 0,0, 0), 1,
                 mk(1,0,1,0, 0,0,0, 0,0, 0,0, 0),
                 mk(0,0,1,0, 0,0,1, 5,1, 0,0, 0), 1};
    // SW x2,0(x1)
    vecs[8]  = '{32'h0020A023, 0, 32'h0, {5'd1, 5'd2, 5'd0},
                 mk(0,0,0,0, 0,0,0, 0,0, 0,0, 0), 2,
                 mk(1,1,1,2, 0,0,0, 0,0, 0,0, 0),
                 mk(0,1,1,2, 0,0,1, 0,0, 0,0, 0), 0};
    // LW x0,0(x1): load completes, write suppressed
    vecs[9]  = '{32'h0000A003, 0, 32'h0, {5'd1, 5'd0, 5'd0},
                 mk(0,0,0,0, 0,0,0, 0,0, 0,0, 0), 1,
                 mk(1,0,1,0, 0,0,0, 0,0, 0,0, 0),
                 mk(0,0,1,0, 0,0,1, 5,0, 0,0, 0), 0};
    // Illegal opcode -> TRAP, only halted high
    vecs[10] = '{32'hFFFFFFFF, 0, 32'h0, {5'd31, 5'd31, 5'd31},
                 mk(0,0,0,0, 0,0,0, 0,0, 0,0, 1), 3, '0, '0, 0};

    rst_n = 1'b0; RUN = 1'b1; rdata_valid = 1'b0; write_done = 1'b0; rdata = 32'd0;

    // Reset state (RUN high must not start anything while in reset)
    repeat (3) cyc();
    samp();
    chk("reset_outs", outs(), '0);
    chk("reset_ir", IR, 32'd0);
    chk("reset_pc", rst_pc, 32'h0000_1000);
    RUN = 1'b0; rst_n = 1'b1;
    cyc();

    // Reset asserted during the fetch-request cycle suppresses the pulse
    RUN = 1'b1;
    cyc(); samp();
    chk("pre_rst_fetch", start_transaction, 1'b1);
    rst_n = 1'b0; #1;
    chk("rst_gates_pulse", start_transaction, 1'b0);
    cyc();
    rst_n = 1'b1; RUN = 1'b0; rdata_valid = 1'b1; rdata = 32'hDEADBEEF;
    n_start = 0;
    repeat (3) begin cyc(); samp(); end
    chk("rst_abandon_nostart", n_start, 0);
    chk("stray_valid_idle_ir", IR, 32'd0);
    rdata_valid = 1'b0;

    // Table-driven instruction runs
    for (int v = 0; v < 11; v++) begin
      int freq_cyc;
      n_start = 0; n_wen = 0; n_pcen = 0;
      RUN = 1'b1;
      cyc(); samp();
      freq_cyc = cyc_cnt;
      chk($sformatf("v%0d_fetch_req", v), {start_transaction, mode, addr_CS}, 4'b1000);
      RUN = 1'b0; write_done = 1'b1;            // RUN dropped mid-instruction; write_done ignored in fetch
      for (int i = 0; i < vecs[v].wait_cyc; i++) begin cyc(); samp(); end
      cyc();
      rdata_valid = 1'b1; rdata = vecs[v].instr; write_done = 1'b0;
      samp();
      cyc();
      rdata = vecs[v].cmp_rdata;                // stray valid in DECODE must not reload IR
      samp();
      cyc();
      rdata_valid = 1'b0;
      samp();
      chk($sformatf("v%0d_exec", v), outs(), vecs[v].exp_exec);
      chk($sformatf("v%0d_ir", v), {IR, rs1, rs2, rd}, {vecs[v].instr, vecs[v].exp_regs});
      if (vecs[v].kind == 0)
        chk($sformatf("v%0d_latency", v), cyc_cnt - freq_cyc, vecs[v].wait_cyc + 3);
      if (vecs[v].kind == 1 || vecs[v].kind == 2) begin
        cyc(); samp();
        chk($sformatf("v%0d_mreq", v), outs(), vecs[v].exp_mreq);
        cyc();
        if (vecs[v].kind == 1) write_done = 1'b1; else rdata_valid = 1'b1;   // wrong completion
        samp();
        chk($sformatf("v%0d_mwait", v), outs(), {1'b0, vecs[v].exp_mreq[17:0]});
        cyc();
        if (vecs[v].kind == 1) begin write_done = 1'b0; rdata_valid = 1'b1; end
        else begin rdata_valid = 1'b0; write_done = 1'b1; end
        samp();
        chk($sformatf("v%0d_done", v), outs(), vecs[v].exp_done);
      end
      if (vecs[v].kind != 3) begin
        cyc();
        rdata_valid = 1'b0; write_done = 1'b0;
        samp();
        repeat (2) begin cyc(); samp(); end
        chk($sformatf("v%0d_pulse_counts", v), {n_start[7:0], n_wen[7:0], n_pcen[7:0]},
            {(vecs[v].kind == 0) ? 8'd1 : 8'd2, 8'(vecs[v].exp_wen), 8'd1});
      end
    end

    // Halted: RUN toggling must not restart fetch
    n_start = 0;
    for (int i = 0; i < 12; i++) begin
      RUN = (i % 2 == 0);
      cyc(); samp();
    end
    chk("trap_no_fetch", n_start, 0);
    chk("trap_halted", halted, 1'b1);

    // Reset releases the trap
    RUN = 1'b0; rst_n = 1'b0;
    cyc(); samp();
    chk("rst_after_trap", {outs(), IR}, '0);
    rst_n = 1'b1;
    cyc();

`ifdef CPU_SEQ_TIMEOUT_EN
    // Fetch never answered: watchdog traps after 8 wait cycles
    RUN = 1'b1;
    cyc(); samp();
    RUN = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc(); samp();
      if (i == 8) chk("wd_not_yet", halted, 1'b0);
    end
    cyc(); samp();
    chk("wd_trap", outs(), mk(0,0,0,0, 0,0,0, 0,0, 0,0, 1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
